// File: rtl/rle_vlc_packer.sv
// Maps zig-zag RLE tokens to variable-length codes (DC size/value, AC escape, EOB)
// and packs them MSB-first into 32-bit words on a valid/ready stream.
module rle_vlc_packer (
  input  logic        clk,
  input  logic        reset,
  output logic        in_rdy,
  input  logic        in_en,
  input  logic [15:0] in_val,
  input  logic [5:0]  in_len,
  input  logic        in_end,
  input  logic        in_dc,
  input  logic        flush,
  output logic        flush_done,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned ACC_W  = 64;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned CODE_W = 24;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned LVL_W  = 12;

  localparam logic [1:0] ST_ACCEPT   = 2'd0;
  localparam logic [1:0] ST_PEND_AC  = 2'd1;
  localparam logic [1:0] ST_EOB_PEND = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_WORD = CNT_W'(32);
  localparam logic [CODE_W-1:0] EOB_CODE = CODE_W'(2'b10);

  // Saturate to the 12-bit symmetric range [-2047, +2047]
  function automatic logic [LVL_W-1:0] sat12(input logic [15:0] v);
    if ($signed(v) > 16'sd2047)       return 12'h7FF;
    else if ($signed(v) < -16'sd2047) return 12'h801;
    else                              return v[LVL_W-1:0];
  endfunction

  function automatic logic [CODE_W-1:0] ac_code(input logic [5:0] run, input logic [LVL_W-1:0] lvl);
    return {6'b000001, run, lvl};
  endfunction

  function automatic logic [3:0] dc_size(input logic [LVL_W-1:0] lvl);
    logic [LVL_W-1:0] mag;
    logic [3:0]       s;
    mag = lvl[LVL_W-1] ? -lvl : lvl;
    s   = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (mag[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

  logic [1:0]        state, state_n;
  logic [ACC_W-1:0]  acc, acc_s, acc_n;
  logic [CNT_W-1:0]  count, cnt_p, count_n, code_sh;
  logic              first, first_n;
  logic              flush_pend, flush_pend_n;
  logic [LVL_W-1:0]  hold_lvl, hold_lvl_n;
  logic [5:0]        hold_run, hold_run_n;
  logic              hold_end, hold_end_n;
  logic [CODE_W-1:0] code, dc_code;
  logic [LEN_W-1:0]  code_len, dc_len;
  logic [LVL_W-1:0]  in_lvl, dc_bits;
  logic [3:0]        dc_s;
  logic              pad, flush_done_n, take, pop, in_rdy_n;

  // Token-side decode of the current input coefficient
  always_comb begin
    in_lvl  = sat12(in_val);
    dc_s    = dc_size(in_lvl);
    dc_bits = in_lvl[LVL_W-1] ? in_lvl - 12'd1 : in_lvl;
    dc_code = (CODE_W'(dc_s) << dc_s) | (CODE_W'(dc_bits) & ((CODE_W'(1) << dc_s) - CODE_W'(1)));
    dc_len  = LEN_W'(dc_s) + LEN_W'(4);
  end

  assign take  = in_en && in_rdy;
  assign pop   = out_valid && out_ready;
  assign acc_s = pop ? (acc << 32) : acc;
  assign cnt_p = pop ? count - CNT_WORD : count;

  // Next-state and code selection: at most one code appended per cycle
  always_comb begin
    state_n      = state;
    first_n      = first;
    flush_pend_n = flush_pend | flush;
    hold_lvl_n   = hold_lvl;
    hold_run_n   = hold_run;
    hold_end_n   = hold_end;
    code         = '0;
    code_len     = '0;
    pad          = 1'b0;
    flush_done_n = 1'b0;
    case (state)
      ST_ACCEPT: begin
        if (take) begin
          if (in_dc) begin
            code     = dc_code;
            code_len = dc_len;
            first_n  = in_end;
          end else if (first) begin
            // Upstream folded a zero DC into the run: emit size-0 DC, replay token next cycle
            code_len   = LEN_W'(4);
            hold_lvl_n = in_lvl;
            hold_run_n = in_len - 6'd1;
            hold_end_n = in_end;
            first_n    = 1'b0;
            state_n    = ST_PEND_AC;
          end else if (in_end && in_lvl == '0) begin
            code     = EOB_CODE;
            code_len = LEN_W'(2);
            first_n  = 1'b1;
          end else begin
            code     = ac_code(in_len, in_lvl);
            code_len = LEN_W'(CODE_W);
            if (in_end) begin
              first_n = 1'b1;
              state_n = ST_EOB_PEND;
            end
          end
        end else if (flush || flush_pend) begin
          flush_pend_n = 1'b0;
          if (count == '0) flush_done_n = 1'b1;
          else             state_n      = ST_FLUSH;
        end
      end
      ST_PEND_AC: begin
        state_n = ST_ACCEPT;
        if (hold_end) first_n = 1'b1;
        if (hold_end && hold_lvl == '0) begin
          code     = EOB_CODE;
          code_len = LEN_W'(2);
        end else begin
          code     = ac_code(hold_run, hold_lvl);
          code_len = LEN_W'(CODE_W);
          if (hold_end) state_n = ST_EOB_PEND;
        end
      end
      ST_EOB_PEND: begin
        code     = EOB_CODE;
        code_len = LEN_W'(2);
        state_n  = ST_ACCEPT;
      end
      ST_FLUSH: begin
        if (cnt_p == '0) begin
          flush_done_n = 1'b1;
          state_n      = ST_ACCEPT;
        end else if (cnt_p < CNT_WORD) begin
          pad = 1'b1;
        end
      end
      default: state_n = ST_ACCEPT;
    endcase
  end

  // Bits below count are always zero, so padding only needs to bump the count
  always_comb begin
    code_sh  = CNT_W'(64) - cnt_p - CNT_W'(code_len);
    acc_n    = acc_s | (ACC_W'(code) << code_sh);
    count_n  = pad ? CNT_WORD : cnt_p + CNT_W'(code_len);
    in_rdy_n = (state_n == ST_ACCEPT) && (count_n <= CNT_WORD) && !flush_pend_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ACCEPT;
      acc        <= '0;
      count      <= '0;
      first      <= 1'b1;
      flush_pend <= 1'b0;
      hold_lvl   <= '0;
      hold_run   <= '0;
      hold_end   <= 1'b0;
      in_rdy     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      count      <= count_n;
      first      <= first_n;
      flush_pend <= flush_pend_n;
      hold_lvl   <= hold_lvl_n;
      hold_run   <= hold_run_n;
      hold_end   <= hold_end_n;
      in_rdy     <= in_rdy_n;
      out_valid  <= count_n >= CNT_WORD;
      out_data   <= acc_n[ACC_W-1:32];
      flush_done <= flush_done_n;
    end
  end

endmodule

// File: tb/tb_rle_vlc_packer.sv
// Directed bench for rle_vlc_packer: hand-computed words plus a bit-queue model
// for the backpressure stream.
module tb_rle_vlc_packer;

  logic        clk = 1'b0;
  logic        reset, in_en, in_end, in_dc, flush, out_ready;
  logic [15:0] in_val;
  logic [5:0]  in_len;
  logic        in_rdy, flush_done, out_valid;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] words[$];
  bit          mq[$];

  rle_vlc_packer dut (
    .clk(clk), .reset(reset), .in_rdy(in_rdy), .in_en(in_en), .in_val(in_val),
    .in_len(in_len), .in_end(in_end), .in_dc(in_dc), .flush(flush),
    .flush_done(flush_done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) words.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] wd(input int i);
    if (i < words.size()) return words[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic send(input logic [15:0] v, input logic [5:0] r, input logic e, input logic d);
    int n = 0;
    while (!in_rdy && n < 100) begin
      step();
      n++;
    end
    if (!in_rdy) begin
      chk("send_rdy_timeout", 32'(in_rdy), 32'd1);
      return;
    end
    in_en = 1'b1; in_val = v; in_len = r; in_end = e; in_dc = d;
    step();
    in_en = 1'b0; in_end = 1'b0; in_dc = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    while (!flush_done && n < 100) begin
      step();
      n++;
    end
    chk("flush_done", 32'(flush_done), 32'd1);
    step();
  endtask

  // Reference: escape code appended to a bit queue
  task automatic model_ac(input logic [15:0] v, input logic [5:0] r);
    int          iv;
    logic [23:0] c;
    iv = int'($signed(v));
    if (iv > 2047)  iv = 2047;
    if (iv < -2047) iv = -2047;
    c = {6'b000001, r, 12'(iv)};
    for (int b = 23; b >= 0; b--) mq.push_back(c[b]);
  endtask

  logic [15:0] s_val[7] = '{16'd5, 16'hFFFD, 16'h7FFF, 16'h8000, 16'd0, 16'd1000, 16'hFC18};
  logic [5:0]  s_run[7] = '{6'd0, 6'd1, 6'd63, 6'd7, 6'd2, 6'd10, 6'd31};

  initial begin
    logic [31:0] w;
    int          nw;
    reset = 1'b1; in_en = 1'b0; in_end = 1'b0; in_dc = 1'b0; flush = 1'b0;
    out_ready = 1'b1; in_val = '0; in_len = '0;
    idle(3);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    reset = 1'b0;
    step();
    chk("rdy_after_rst", 32'(in_rdy), 32'd1);

    // DC 5, AC(2,-3), EOB -> 33 bits
    words.delete();
    send(16'd5, 6'd0, 1'b0, 1'b1);
    send(16'hFFFD, 6'd2, 1'b0, 1'b0);
    send(16'd0, 6'd5, 1'b1, 1'b0);
    idle(3);
    chk("t1_nwords", 32'(words.size()), 32'd1);
    chk("t1_word0", wd(0), 32'h3A08_5FFB);
    do_flush();
    chk("t1_nwords_flush", 32'(words.size()), 32'd2);
    chk("t1_pad_word", wd(1), 32'h0000_0000);

    // First token without DC: forced '0000' then escape with run-1
    words.delete();
    send(16'd7, 6'd3, 1'b0, 1'b0);
    idle(3);
    chk("t2_no_valid", 32'(out_valid), 32'd0);
    chk("t2_no_word", 32'(words.size()), 32'd0);
    do_flush();
    chk("t2_word", wd(0), 32'h0042_0070);

    // End token with nonzero value: escape then EOB next cycle
    words.delete();
    send(16'd1, 6'd0, 1'b1, 1'b0);
    chk("t3_rdy_low_eob", 32'(in_rdy), 32'd0);
    idle(2);
    do_flush();
    chk("t3_word", wd(0), 32'h0400_0180);

    // Saturation: DC -32768 then AC +32767
    words.delete();
    send(16'h8000, 6'd0, 1'b0, 1'b1);
    send(16'h7FFF, 6'd0, 1'b0, 1'b0);
    idle(3);
    do_flush();
    chk("t4_nwords", 32'(words.size()), 32'd2);
    chk("t4_word0", wd(0), 32'hB000_080F);
    chk("t4_word1", wd(1), 32'hFE00_0000);

    // Backpressure stream against the bit-queue model
    words.delete();
    mq.delete();
    out_ready = 1'b0;
    send(s_val[0], s_run[0], 1'b0, 1'b0);
    model_ac(s_val[0], s_run[0]);
    chk("t5_rdy_24", 32'(in_rdy), 32'd1);
    send(s_val[1], s_run[1], 1'b0, 1'b0);
    model_ac(s_val[1], s_run[1]);
    idle(4);
    chk("t5_rdy_48", 32'(in_rdy), 32'd0);
    chk("t5_valid_held", 32'(out_valid), 32'd1);
    chk("t5_no_pop", 32'(words.size()), 32'd0);
    out_ready = 1'b1;
    for (int i = 2; i < 7; i++) begin
      send(s_val[i], s_run[i], 1'b0, 1'b0);
      model_ac(s_val[i], s_run[i]);
    end
    idle(3);
    do_flush();
    while (mq.size() % 32 != 0) mq.push_back(1'b0);
    nw = mq.size() / 32;
    chk("t5_nwords", 32'(words.size()), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      for (int b = 31; b >= 0; b--) w[b] = mq.pop_front();
      chk($sformatf("t5_word%0d", k), wd(k), w);
    end

    // Reset mid-block with 20 bits buffered
    words.delete();
    send(16'd1, 6'd0, 1'b0, 1'b1);
    send(16'd2047, 6'd0, 1'b0, 1'b1);
    idle(1);
    reset = 1'b1;
    step();
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_rdy", 32'(in_rdy), 32'd0);
    reset = 1'b0;
    step();
    chk("t6_rdy_after", 32'(in_rdy), 32'd1);
    chk("t6_valid_after", 32'(out_valid), 32'd0);
    chk("t6_no_partial", 32'(words.size()), 32'd0);
    send(16'd2, 6'd1, 1'b0, 1'b0);
    idle(3);
    do_flush();
    chk("t6_nwords", 32'(words.size()), 32'd1);
    chk("t6_word", wd(0), 32'h0040_0020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
